// File: rtl/wc_tile_feeder.sv
// Input-side streamer for the Winograd core: turns a serial sample stream into
// overlapping TILE-sample tiles. Each tile after the first keeps the last OVL samples
// of the previous one. A short final tile is zero-padded. Both sides use valid/ready.
module wc_tile_feeder #(
    parameter int DW   = 10,
    parameter int TILE = 7,
    parameter int STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DW-1:0]        s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 s_last,
    output logic [DW*TILE-1:0]   tile,
    output logic                 tile_valid,
    input  logic                 tile_ready,
    output logic                 tile_first,
    output logic                 tile_last
);

    localparam int OVL = TILE - STEP;
    localparam int CW  = $clog2(TILE + 1);
    localparam logic [CW-1:0] TILE_C = CW'(TILE);
    localparam logic [CW-1:0] OVL_C  = CW'(OVL);

    typedef enum logic [1:0] {FILL, REFILL, PAD, EMIT} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_inc;
    logic [DW-1:0]   window [TILE];
    logic            row_first;
    logic            accept;
    logic            do_shift;
    logic            clear_win;
    logic [DW-1:0]   shift_in;

    assign accept    = s_valid & s_ready;
    assign count_inc = count + 1'b1;

    // Window control: shift on an accepted sample or a pad cycle, clear when a row ends.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        do_shift  = 1'b0;
        shift_in  = '0;
        clear_win = 1'b0;
        case (state)
            FILL, REFILL: begin
                do_shift = accept;
                shift_in = s_data;
            end
            PAD:     do_shift = 1'b1;
            EMIT:    clear_win = tile_ready & tile_last;
            default: ;
        endcase
    end

    // Sample window: new entry at TILE-1, older entries move toward element 0.
    // NOTE: the window is cleared on reset because the idle tile bus must read as zero.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_win) begin
            for (int i = 0; i < TILE; i++) window[i] <= '0;
        end else if (do_shift) begin
            for (int i = 0; i < TILE - 1; i++) window[i] <= window[i+1];
            window[TILE-1] <= shift_in;
        end
    end

    // Tile bus: element 0 (oldest sample) sits in the most significant slice.
    for (genvar i = 0; i < TILE; i++) begin : g_pack
        assign tile[DW*(TILE-i)-1 -: DW] = window[i];
    end

    // Sequencer: fill, pad and emit with registered handshake outputs.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            count      <= '0;
            s_ready    <= 1'b0;
            tile_valid <= 1'b0;
            tile_first <= 1'b0;
            tile_last  <= 1'b0;
            row_first  <= 1'b1;
        end else begin
            case (state)
                FILL, REFILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        count <= count_inc;
                        if (count_inc == TILE_C) begin
                            state      <= EMIT;
                            s_ready    <= 1'b0;
                            tile_valid <= 1'b1;
                            tile_first <= row_first;
                            tile_last  <= s_last;
                        end else if (s_last) begin
                            state   <= PAD;
                            s_ready <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    count <= count_inc;
                    if (count_inc == TILE_C) begin
                        state      <= EMIT;
                        tile_valid <= 1'b1;
                        tile_first <= row_first;
                        tile_last  <= 1'b1;
                    end
                end
                EMIT: begin
                    if (tile_ready) begin
                        tile_valid <= 1'b0;
                        tile_first <= 1'b0;
                        tile_last  <= 1'b0;
                        s_ready    <= 1'b1;
                        row_first  <= tile_last;
                        if (tile_last) begin
                            state <= FILL;
                            count <= '0;
                        end else begin
                            state <= REFILL;
                            count <= OVL_C;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Self-checking bench for wc_tile_feeder: directed rows plus randomized rows with
// random stalls, compared against a tile model built from sample indices.
module tb_wc_tile_feeder;

    localparam int DW   = 10;
    localparam int TILE = 7;
    localparam int STEP = 4;
    localparam int TW   = DW * TILE;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic [TW-1:0]   tile;
    logic            tile_valid;
    logic            tile_ready;
    logic            tile_first;
    logic            tile_last;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] row [$];
    int            acc_at [$];
    int            pad_cyc;

    wc_tile_feeder #(.DW(DW), .TILE(TILE), .STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_last     (s_last),
        .tile       (tile),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_first (tile_first),
        .tile_last  (tile_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Tile t covers row indices t*STEP .. t*STEP+TILE-1; indices past the row read as zero.
    function automatic logic [TW-1:0] model_tile(input int t);
        logic [TW-1:0] v = '0;
        for (int e = 0; e < TILE; e++) begin
            int idx = t * STEP + e;
            if (idx < row.size()) v[TW-1-DW*e -: DW] = row[idx];
        end
        return v;
    endfunction

    // Tiles continue until one covers the last sample of the row.
    function automatic int n_tiles(input int n);
        int t = 0;
        while (t * STEP + TILE - 1 < n - 1) t++;
        return t + 1;
    endfunction

    task automatic load_random_row(input int n);
        row.delete();
        for (int i = 0; i < n; i++) row.push_back(10'($urandom_range(0, 1023)));
    endtask

    task automatic feed_manual(input int n, input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = row[i];
            s_last  = last_on_end && (i == n - 1);
            check("feed_s_ready", TW'(s_ready), TW'(1));
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Streams the current row, optionally with random source/sink stalls, and checks every
    // cycle where a tile is presented against the model.
    task automatic run_row(input bit stall, input string tag);
        int  n   = row.size();
        int  nt  = n_tiles(n);
        int  idx = 0;
        int  t   = 0;
        int  cyc = 0;
        int  pad = 0;
        bit  seen = 1'b0;
        bit  sr, tv;
        acc_at.delete();
        while (t < nt && cyc < 2000) begin
            s_valid    = (idx < n) && (!stall || $urandom_range(0, 3) != 0);
            s_data     = (idx < n) ? row[idx] : '0;
            s_last     = (idx == n - 1);
            tile_ready = !stall || $urandom_range(0, 2) != 0;
            sr = s_ready;
            tv = tile_valid;
            if (tv) begin
                if (!seen) begin
                    acc_at.push_back(idx);
                    seen = 1'b1;
                end
                check({tag, "_tile"},  tile, model_tile(t));
                check({tag, "_first"}, TW'(tile_first), TW'(t == 0));
                check({tag, "_last"},  TW'(tile_last),  TW'(t == nt - 1));
                check({tag, "_sready_emit"}, TW'(s_ready), TW'(0));
            end else if (!sr) begin
                pad++;
            end
            step();
            cyc++;
            if (s_valid && sr) idx++;
            if (tv && tile_ready) begin
                t++;
                seen = 1'b0;
            end
        end
        s_valid    = 1'b0;
        s_last     = 1'b0;
        tile_ready = 1'b0;
        check({tag, "_tiles_done"}, TW'(t), TW'(nt));
        check({tag, "_samples_done"}, TW'(idx), TW'(n));
        pad_cyc = pad;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tile"},   tile, '0);
        check({tag, "_tvalid"}, TW'(tile_valid), TW'(0));
        check({tag, "_first"},  TW'(tile_first), TW'(0));
        check({tag, "_last"},   TW'(tile_last),  TW'(0));
        check({tag, "_sready"}, TW'(s_ready),    TW'(0));
    endtask

    initial begin
        logic [TW-1:0] exp;
        logic [TW-1:0] t1_exp;
        t1_exp = 70'b0000000010_1111110110_0000000011_0000000100_1111110011_1111101110_1111110000;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; tile_ready = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check("post_reset_sready", TW'(s_ready), TW'(1));
        check("post_reset_tvalid", TW'(tile_valid), TW'(0));

        // 1: full 7-sample row, one-cycle latency from the 7th accept
        row = '{10'sd2, -10'sd10, 10'sd3, 10'sd4, -10'sd13, -10'sd18, -10'sd16};
        for (int i = 0; i < TILE; i++) begin
            s_valid = 1'b1;
            s_data  = row[i];
            s_last  = (i == TILE - 1);
            check("t1_sready", TW'(s_ready), TW'(1));
            step();
            if (i < TILE - 1) check("t1_tvalid_early", TW'(tile_valid), TW'(0));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("t1_tvalid", TW'(tile_valid), TW'(1));
        check("t1_tile_literal", tile, t1_exp);
        check("t1_tile_model", tile, model_tile(0));
        check("t1_first", TW'(tile_first), TW'(1));
        check("t1_last", TW'(tile_last), TW'(1));
        check("t1_sready_emit", TW'(s_ready), TW'(0));
        tile_ready = 1'b1;
        step();
        tile_ready = 1'b0;
        check("t1_tvalid_drop", TW'(tile_valid), TW'(0));
        check("t1_sready_back", TW'(s_ready), TW'(1));

        // 2: 11-sample row, two tiles, 4 refill accepts between them
        row = '{-10'sd19, -10'sd6, 10'sd3, -10'sd9, -10'sd12, 10'sd11, -10'sd4,
                10'sd5, 10'sd6, 10'sd7, 10'sd8};
        run_row(1'b0, "t2");
        check("t2_ntiles", TW'(acc_at.size()), TW'(2));
        if (acc_at.size() == 2) check("t2_refill_accepts", TW'(acc_at[1] - acc_at[0]), TW'(STEP));
        check("t2_pad", TW'(pad_cyc), TW'(0));

        // 3: backpressure for 5 cycles; held tile and flags stay constant
        load_random_row(TILE);
        feed_manual(TILE, 1'b1);
        exp = model_tile(0);
        s_valid = 1'b1;
        s_data  = 10'h155;
        s_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("t3_tvalid_hold", TW'(tile_valid), TW'(1));
            check("t3_tile_hold", tile, exp);
            check("t3_first_hold", TW'(tile_first), TW'(1));
            check("t3_last_hold", TW'(tile_last), TW'(1));
            check("t3_sready_hold", TW'(s_ready), TW'(0));
            step();
        end
        tile_ready = 1'b1;
        check("t3_tile_c6", tile, exp);
        step();
        tile_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("t3_tvalid_drop", TW'(tile_valid), TW'(0));
        check("t3_sready_back", TW'(s_ready), TW'(1));

        // 6: single-sample row right after the stall -> nothing stalled leaks in
        row = '{-10'sd5};
        run_row(1'b0, "t6");
        check("t6_pad", TW'(pad_cyc), TW'(TILE - 1));

        // 4: short final tile, 2 pad cycles
        row.delete();
        for (int i = 1; i <= 9; i++) row.push_back(10'(i));
        run_row(1'b0, "t4");
        check("t4_pad", TW'(pad_cyc), TW'(2));

        // 5: reset mid-row drops partial data
        load_random_row(4);
        feed_manual(4, 1'b0);
        rst_n   = 1'b0;
        s_valid = 1'b1;
        s_data  = 10'h3ff;
        step();
        check_all_zero("t5_rst_a");
        step();
        check_all_zero("t5_rst_b");
        rst_n   = 1'b1;
        s_valid = 1'b0;
        step();
        check("t5_sready", TW'(s_ready), TW'(1));
        check("t5_tile_clear", tile, '0);
        load_random_row(TILE);
        run_row(1'b0, "t5");

        // random rows with random stalls on both sides
        for (int r = 0; r < 12; r++) begin
            load_random_row($urandom_range(1, 20));
            run_row(1'b1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
